bank_write_ctrl: RTL and testbench
==================================

Name: bank_write_ctrl

Overview:
- Ping-pong write scheduler for the two 200-entry spectrogram channel-memory banks, addressed as {bank, idx[7:0]}.
- Takes digitised samples during an acoustic emission (AE) trigger window and generates write enables and addresses.
- Produces the bank_full / memorization_completed / idx_final / bank signals consumed by the readout FSM.
- Tracks which bank is still being read out so that an unread bank is never overwritten.

Parameters:
- DATA_W, 16, sample width.
- DEPTH, 200, entries per bank; must be ≤ 256.
- POST_TRIG, 16, valid samples still written after trigger deasserts; range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- trigger  in  1  high while the AE is above threshold.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  DATA_W  incoming sample.
- rd_done  in  2  one-cycle pulse from readout: rd_done[b] means bank b has been fully read and is free.
- wr_en  out  1  memory write strobe.
- wr_addr  out  9  {wr_bank, idx}.
- wr_data  out  DATA_W  registered copy of sample_data.
- bank  out  1  bank holding the most recent write.
- bank0_full  out  1  one-cycle pulse when bank 0 has just been filled.
- bank1_full  out  1  one-cycle pulse when bank 1 has just been filled.
- memorization_completed  out  1  one-cycle pulse at the end of an acquisition.
- idx_final  out  8  index of the last write of the acquisition; held until the next completion.
- overflow  out  1  sticky; set when samples are dropped; cleared by reset only.

Behaviour:
- Reset (synchronous): all outputs 0. Internal state: FSM in IDLE, idx=0, wr_bank=0, busy=2'b00, post counter=0.
- All outputs are registered. A sample accepted in cycle N produces wr_en/wr_addr/wr_data in cycle N+1. Full and completion pulses are issued in the same cycle as the write that causes them.
- States:
  - IDLE: wait for trigger.
  - FILL: write while trigger is high.
  - TAIL: write POST_TRIG more samples after trigger falls.
  - STALL: the target bank is busy; samples are dropped.
- IDLE -> FILL when trigger=1.
  - Target bank selection: wr_bank if not busy, else the other bank if free.
  - If both banks are busy -> STALL.
  - A sample valid in the same cycle as trigger rises is written, at idx 0.
- Write rule, in FILL/TAIL with sample_valid=1: write at {wr_bank, idx}, then idx <= idx+1.
- Bank switch when idx == DEPTH-1 on a write:
  - Pulse bank<wr_bank>_full, set busy[wr_bank], toggle wr_bank, set idx=0.
  - If the new bank is busy -> STALL.
- FILL -> TAIL when trigger=0 is sampled; post counter is cleared. In TAIL, each write increments the counter.
- Completion: on the POST_TRIG-th TAIL write:
  - Pulse memorization_completed.
  - idx_final <= idx of that write; bank <= wr_bank.
  - Set busy[wr_bank]; set idx=0; go to IDLE.
  - The next acquisition starts in the other bank if it is free.
- Retrigger: trigger=1 while in TAIL -> FILL; post counter cleared; idx continues.
- Completion on the last entry (index DEPTH-1): the bankN_full pulse and memorization_completed assert in the same cycle, with idx_final = DEPTH-1.
- STALL:
  - sample_valid samples are dropped and overflow is set.
  - When busy[wr_bank] clears -> FILL, or -> TAIL if trigger=0.
  - If trigger has been low for POST_TRIG dropped samples -> IDLE, with no completion pulse.
- rd_done[b] clears busy[b]. If rd_done[b] and a set of busy[b] occur in the same cycle, the set wins.
- sample_valid=0 in any state: no write and no counter change.
- Reset mid-acquisition: abort immediately, no pulses; memory contents are don't-care.

Optional Feature:
- Macro: BANK_WRITE_CTRL_DROP_CNT_EN.
- With the macro defined:
  - Adds output drop_cnt[7:0]: saturating count of dropped samples, reset to 0.
  - Adds input drop_clr: a one-cycle pulse that clears drop_cnt to 0.
  - If drop_clr and a drop occur in the same cycle, the clear wins.
- Without the macro: neither port exists; only the sticky overflow flag is provided.

Decomposition:
- Shared package bank_ctrl_pkg holds:
  - The state enum (IDLE, FILL, TAIL, STALL).
  - BANK_DEPTH=200.
  - ADDR_W=9.
  - The bank index type.
- The readout FSM also uses BANK_DEPTH from this package.
- One sub-module: bank_busy_tracker.
  - Inputs: set[1:0], rd_done[1:0].
  - Output: busy[1:0].
  - Set has priority over clear.

Test Plan:
- Short AE: trigger high for 10 valid samples, POST_TRIG=16, continuous valid -> 26 writes at addr 0..25 of bank 0, memorization_completed pulse, idx_final=25, bank=0, no full pulses.
- Long AE: trigger held for 250 samples -> bank0_full pulse on the write to addr 199; writes continue at {1,0}; completion in bank 1 with idx_final=65.
- Both banks busy: fill bank 0 and bank 1 with no rd_done -> STALL and overflow=1, no writes. Then rd_done=2'b01 -> writing resumes at {0,0}.
- Retrigger: trigger falls, 5 TAIL samples, trigger rises again -> return to FILL; completion needs 16 post samples after the final fall.
- Boundary: trigger released so that the 16th post sample lands at idx 199 -> bank0_full and memorization_completed in the same cycle, idx_final=199.
- Reset asserted mid-FILL at idx 50 -> next cycle all outputs 0; a new trigger writes at {0,0}.

Source files
------------

// File: rtl/bank_ctrl_pkg.sv
// Shared types and constants for the spectrogram channel-memory bank writer and readout.
package bank_ctrl_pkg;

  localparam int unsigned BANK_DEPTH = 200;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned POST_W     = 8;
  localparam int unsigned DROP_W     = 8;

  typedef logic [IDX_W-1:0] bank_idx_t;
  typedef logic             bank_sel_t;

  // Memory address as seen by the channel-memory banks: {bank, idx}.
  typedef struct packed {
    bank_sel_t bank;
    bank_idx_t idx;
  } wr_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    TAIL  = 2'd2,
    STALL = 2'd3
  } wr_state_e;

endpackage

// File: rtl/bank_busy_tracker.sv
// Per-bank busy flags: set when a bank is handed to readout, cleared by rd_done; set wins.
module bank_busy_tracker (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] set,
  input  logic [1:0] rd_done,
  output logic [1:0] busy
);

  logic [1:0] busy_q, busy_d;

  // Next busy state; a same-cycle set overrides the clear.
  always_comb begin
    busy_d = (busy_q & ~rd_done) | set;
  end

  // Busy register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 2'b00;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/bank_write_ctrl.sv
// Ping-pong write scheduler for the two spectrogram channel-memory banks.
// Optional macro BANK_WRITE_CTRL_DROP_CNT_EN adds drop_clr / drop_cnt (saturating drop counter).
module bank_write_ctrl
  import bank_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = BANK_DEPTH,
  parameter int unsigned POST_TRIG = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef BANK_WRITE_CTRL_DROP_CNT_EN
  input  logic              drop_clr,
  output logic [DROP_W-1:0] drop_cnt,
`endif
  input  logic              trigger,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [1:0]        rd_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              bank,
  output logic              bank0_full,
  output logic              bank1_full,
  output logic              memorization_completed,
  output logic [IDX_W-1:0]  idx_final,
  output logic              overflow
);

  localparam bank_idx_t         LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [POST_W-1:0] POST_LAST = POST_W'(POST_TRIG);

  wr_state_e         state_q, state_d;
  bank_idx_t         idx_q, idx_d;
  bank_sel_t         wr_bank_q, wr_bank_d;
  logic [POST_W-1:0] post_q, post_d;

  logic              wr_en_q, wr_en_d;
  wr_addr_t          wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  bank_sel_t         bank_q, bank_d;
  logic              full0_q, full0_d;
  logic              full1_q, full1_d;
  logic              comp_q, comp_d;
  bank_idx_t         idx_final_q, idx_final_d;
  logic              overflow_q, overflow_d;

  logic [1:0]        busy;
  logic [1:0]        busy_set_c;
  logic              active_c;
  logic              drop_c;
  logic              last_c;
  bank_sel_t         tgt_c;
  logic [POST_W-1:0] post_inc_c;

  bank_busy_tracker u_busy (
    .clk     (clk),
    .reset   (reset),
    .set     (busy_set_c),
    .rd_done (rd_done),
    .busy    (busy)
  );

  // Next-state, write generation, bank switching and completion.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_bank_d   = wr_bank_q;
    post_d      = post_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    bank_d      = bank_q;
    full0_d     = 1'b0;
    full1_d     = 1'b0;
    comp_d      = 1'b0;
    idx_final_d = idx_final_q;
    overflow_d  = overflow_q;
    busy_set_c  = 2'b00;
    active_c    = 1'b0;
    drop_c      = 1'b0;
    last_c      = 1'b0;
    tgt_c       = wr_bank_q;
    post_inc_c  = post_q + POST_W'(1);

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          if (!busy[wr_bank_q]) begin
            active_c = 1'b1;
          end else if (!busy[~wr_bank_q]) begin
            active_c = 1'b1;
            tgt_c    = ~wr_bank_q;
          end else begin
            state_d = STALL;
            drop_c  = sample_valid;
          end
          if (active_c) begin
            state_d   = FILL;
            wr_bank_d = tgt_c;
          end
        end
      end
      FILL, TAIL: begin
        active_c = 1'b1;
        state_d  = trigger ? FILL : TAIL;
      end
      STALL: begin
        if (!busy[wr_bank_q]) begin
          active_c = 1'b1;
          state_d  = trigger ? FILL : TAIL;
        end else begin
          drop_c = sample_valid;
        end
      end
      default: state_d = IDLE;
    endcase

    // The post window counts valid samples seen since the last trigger-high sample.
    if (trigger) begin
      post_d = '0;
    end

    if (drop_c) begin
      overflow_d = 1'b1;
      if (!trigger) begin
        post_d = post_inc_c;
        if (post_inc_c == POST_LAST) begin
          state_d = IDLE;
          post_d  = '0;
        end
      end
    end

    if (active_c && sample_valid) begin
      wr_en_d   = 1'b1;
      wr_addr_d = '{bank: tgt_c, idx: idx_q};
      wr_data_d = sample_data;
      bank_d    = tgt_c;
      idx_d     = idx_q + IDX_W'(1);
      last_c    = !trigger && (post_inc_c == POST_LAST);
      if (!trigger) begin
        post_d = post_inc_c;
      end
      if (idx_q == LAST_IDX) begin
        full0_d           = (tgt_c == 1'b0);
        full1_d           = (tgt_c == 1'b1);
        busy_set_c[tgt_c] = 1'b1;
        wr_bank_d         = ~tgt_c;
        idx_d             = '0;
        if (busy[~tgt_c]) begin
          state_d = STALL;
        end
      end
      if (last_c) begin
        comp_d            = 1'b1;
        idx_final_d       = idx_q;
        busy_set_c[tgt_c] = 1'b1;
        wr_bank_d         = ~tgt_c;
        idx_d             = '0;
        post_d            = '0;
        state_d           = IDLE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wr_bank_q   <= 1'b0;
      post_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      bank_q      <= 1'b0;
      full0_q     <= 1'b0;
      full1_q     <= 1'b0;
      comp_q      <= 1'b0;
      idx_final_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_bank_q   <= wr_bank_d;
      post_q      <= post_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      bank_q      <= bank_d;
      full0_q     <= full0_d;
      full1_q     <= full1_d;
      comp_q      <= comp_d;
      idx_final_q <= idx_final_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef BANK_WRITE_CTRL_DROP_CNT_EN
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating dropped-sample count; a same-cycle clear wins over a drop.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) begin
      drop_cnt_d = '0;
    end else if (drop_c && (drop_cnt_q != {DROP_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign wr_en                  = wr_en_q;
  assign wr_addr                = wr_addr_q;
  assign wr_data                = wr_data_q;
  assign bank                   = bank_q;
  assign bank0_full             = full0_q;
  assign bank1_full             = full1_q;
  assign memorization_completed = comp_q;
  assign idx_final              = idx_final_q;
  assign overflow               = overflow_q;

endmodule

// File: tb/tb_bank_write_ctrl.sv
// Testbench for bank_write_ctrl: vector table, directed corner sequences, randomized run vs. reference model.
module tb_bank_write_ctrl;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned DEPTH     = 200;
  localparam int unsigned POST_TRIG = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              trigger;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [1:0]        rd_done;
  logic              wr_en;
  logic [8:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              bank;
  logic              bank0_full;
  logic              bank1_full;
  logic              memorization_completed;
  logic [7:0]        idx_final;
  logic              overflow;
`ifdef BANK_WRITE_CTRL_DROP_CNT_EN
  logic              drop_clr;
  logic [7:0]        drop_cnt;
`endif

  bit tb_clr = 1'b0;

  always #5 clk = ~clk;

  bank_write_ctrl #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .POST_TRIG (POST_TRIG)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
`ifdef BANK_WRITE_CTRL_DROP_CNT_EN
    .drop_clr               (drop_clr),
    .drop_cnt               (drop_cnt),
`endif
    .trigger                (trigger),
    .sample_valid           (sample_valid),
    .sample_data            (sample_data),
    .rd_done                (rd_done),
    .wr_en                  (wr_en),
    .wr_addr                (wr_addr),
    .wr_data                (wr_data),
    .bank                   (bank),
    .bank0_full             (bank0_full),
    .bank1_full             (bank1_full),
    .memorization_completed (memorization_completed),
    .idx_final              (idx_final),
    .overflow               (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: acquisition in progress / stalled, current bank and fill level, busy banks.
  bit m_acq, m_stall;
  int m_bank, m_idx, m_post;
  bit m_busy [2];
  int e_wr_en, e_addr, e_data, e_bank, e_f0, e_f1, e_comp, e_idxf, e_ovf, e_drop;

  task automatic model_reset();
    m_acq = 0; m_stall = 0; m_bank = 0; m_idx = 0; m_post = 0;
    m_busy[0] = 0; m_busy[1] = 0;
    e_wr_en = 0; e_addr = 0; e_data = 0; e_bank = 0; e_f0 = 0; e_f1 = 0;
    e_comp = 0; e_idxf = 0; e_ovf = 0; e_drop = 0;
  endtask

  task automatic model_step(input bit trg, input bit vld, input int data, input bit [1:0] rd, input bit clr);
    bit       go;
    bit       fin;
    bit       dropped;
    bit [1:0] setm;
    int       pick;
    go = 0; fin = 0; dropped = 0; setm = 2'b00;
    e_wr_en = 0; e_f0 = 0; e_f1 = 0; e_comp = 0;

    if (!m_acq) begin
      if (trg) begin
        m_acq = 1;
        pick  = m_busy[m_bank] ? 1 - m_bank : m_bank;
        if (m_busy[pick]) m_stall = 1;
        else begin m_bank = pick; go = 1; end
      end
    end else if (m_stall) begin
      if (!m_busy[m_bank]) begin m_stall = 0; go = 1; end
    end else begin
      go = 1;
    end

    if (trg) m_post = 0;

    if (m_stall && vld) begin
      dropped = 1;
      e_ovf   = 1;
      if (!trg) begin
        m_post++;
        if (m_post == POST_TRIG) begin m_acq = 0; m_stall = 0; m_post = 0; end
      end
    end

    if (clr) e_drop = 0;
    else if (dropped && e_drop < 255) e_drop++;

    if (go && vld) begin
      e_wr_en = 1;
      e_addr  = m_bank * 256 + m_idx;
      e_data  = data;
      e_bank  = m_bank;
      if (!trg) m_post++;
      fin = !trg && (m_post == POST_TRIG);
      if (m_idx == DEPTH - 1) begin
        if (m_bank == 0) e_f0 = 1; else e_f1 = 1;
        setm[m_bank] = 1'b1;
      end
      if (fin) begin
        e_comp = 1;
        e_idxf = m_idx;
        setm[m_bank] = 1'b1;
      end
      if (m_idx == DEPTH - 1 || fin) begin
        if (!fin && m_busy[1 - m_bank]) m_stall = 1;
        m_bank = 1 - m_bank;
        m_idx  = 0;
        if (fin) begin m_acq = 0; m_post = 0; end
      end else begin
        m_idx++;
      end
    end

    for (int b = 0; b < 2; b++) m_busy[b] = setm[b] || (m_busy[b] && !rd[b]);
  endtask

  task automatic compare_all();
    chk("mdl_wr_en", int'(wr_en), e_wr_en);
    if (e_wr_en != 0) begin
      chk("mdl_wr_addr", int'(wr_addr), e_addr);
      chk("mdl_wr_data", int'(wr_data), e_data);
    end
    chk("mdl_bank", int'(bank), e_bank);
    chk("mdl_bank0_full", int'(bank0_full), e_f0);
    chk("mdl_bank1_full", int'(bank1_full), e_f1);
    chk("mdl_completed", int'(memorization_completed), e_comp);
    chk("mdl_idx_final", int'(idx_final), e_idxf);
    chk("mdl_overflow", int'(overflow), e_ovf);
`ifdef BANK_WRITE_CTRL_DROP_CNT_EN
    chk("mdl_drop_cnt", int'(drop_cnt), e_drop);
`endif
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input bit trg, input bit vld, input bit [1:0] rd);
    trigger      = trg;
    sample_valid = vld;
    sample_data  = DATA_W'($urandom);
    rd_done      = rd;
`ifdef BANK_WRITE_CTRL_DROP_CNT_EN
    drop_clr     = tb_clr;
`endif
    @(posedge clk);
    if (reset) model_reset();
`ifdef BANK_WRITE_CTRL_DROP_CNT_EN
    else model_step(trg, vld, int'(sample_data), rd, tb_clr);
`else
    else model_step(trg, vld, int'(sample_data), rd, 1'b0);
`endif
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 2'b00);
    reset = 1'b0;
  endtask

  typedef struct {
    bit trg;
    bit vld;
    int exp_wr_en;
    int exp_addr;
    int exp_comp;
    int exp_idxf;
  } vec_t;

  vec_t tbl [28];

  initial begin
    int comps;
    int phase_left;
    bit rtrig;

    // Short AE: 10 trigger-high samples, 16 post samples, bank 0 addresses 0..25.
    for (int i = 0; i < 28; i++) begin
      tbl[i].trg       = (i < 10);
      tbl[i].vld       = (i < 26);
      tbl[i].exp_wr_en = (i < 26) ? 1 : 0;
      tbl[i].exp_addr  = i;
      tbl[i].exp_comp  = (i == 25) ? 1 : 0;
      tbl[i].exp_idxf  = (i >= 25) ? 25 : 0;
    end

    reset = 1'b1; trigger = 1'b0; sample_valid = 1'b0; sample_data = '0; rd_done = 2'b00;
`ifdef BANK_WRITE_CTRL_DROP_CNT_EN
    drop_clr = 1'b0;
`endif
    model_reset();
    do_reset();
    do_reset();
    chk("reset_wr_addr", int'(wr_addr), 0);
    chk("reset_wr_data", int'(wr_data), 0);

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].trg, tbl[i].vld, 2'b00);
      chk("tbl_wr_en", int'(wr_en), tbl[i].exp_wr_en);
      if (tbl[i].exp_wr_en != 0) chk("tbl_wr_addr", int'(wr_addr), tbl[i].exp_addr);
      chk("tbl_completed", int'(memorization_completed), tbl[i].exp_comp);
      chk("tbl_idx_final", int'(idx_final), tbl[i].exp_idxf);
      chk("tbl_full", int'(bank0_full | bank1_full), 0);
      chk("tbl_bank", int'(bank), 0);
    end

    // Long AE: 250 trigger-high samples crosses into bank 1, completes at idx 65.
    do_reset();
    for (int k = 0; k < 266; k++) begin
      step(k < 250, 1'b1, 2'b00);
      if (k == 199) begin
        chk("long_full0", int'(bank0_full), 1);
        chk("long_addr199", int'(wr_addr), 199);
      end
      if (k == 200) chk("long_addr_b1_0", int'(wr_addr), 256);
      if (k == 265) begin
        chk("long_completed", int'(memorization_completed), 1);
        chk("long_idx_final", int'(idx_final), 65);
        chk("long_bank", int'(bank), 1);
      end
    end

    // Both banks busy: stall and drop, then free bank 0 and resume at {0,0}.
    do_reset();
    for (int k = 0; k < 410; k++) begin
      step(1'b1, 1'b1, 2'b00);
      if (k == 399) begin
        chk("stall_full1", int'(bank1_full), 1);
        chk("stall_ovf_before", int'(overflow), 0);
      end
      if (k == 405) begin
        chk("stall_no_write", int'(wr_en), 0);
        chk("stall_overflow", int'(overflow), 1);
      end
    end
    step(1'b1, 1'b0, 2'b01);
    step(1'b1, 1'b1, 2'b00);
    chk("stall_resume_wr_en", int'(wr_en), 1);
    chk("stall_resume_addr", int'(wr_addr), 0);

    // Retrigger during the post window restarts the post count.
    do_reset();
    comps = 0;
    for (int k = 0; k < 44; k++) begin
      step(!((k >= 20 && k < 25) || k >= 28), 1'b1, 2'b00);
      if (k < 43) comps += int'(memorization_completed);
    end
    chk("retrig_early_completions", comps, 0);
    chk("retrig_completed", int'(memorization_completed), 1);
    chk("retrig_idx_final", int'(idx_final), 43);

    // Completion lands on the last entry of bank 0.
    do_reset();
    for (int k = 0; k < 200; k++) step(k < 184, 1'b1, 2'b00);
    chk("bnd_full0", int'(bank0_full), 1);
    chk("bnd_completed", int'(memorization_completed), 1);
    chk("bnd_idx_final", int'(idx_final), 199);

    // Reset mid-fill at idx 50, then a fresh trigger starts at {0,0}.
    do_reset();
    for (int k = 0; k < 50; k++) step(1'b1, 1'b1, 2'b00);
    reset = 1'b1;
    step(1'b1, 1'b1, 2'b00);
    reset = 1'b0;
    chk("rst_mid_wr_en", int'(wr_en), 0);
    chk("rst_mid_wr_addr", int'(wr_addr), 0);
    chk("rst_mid_wr_data", int'(wr_data), 0);
    chk("rst_mid_idx_final", int'(idx_final), 0);
    step(1'b1, 1'b1, 2'b00);
    chk("rst_new_wr_en", int'(wr_en), 1);
    chk("rst_new_addr", int'(wr_addr), 0);

    // Randomized traffic: bursts of trigger, gappy valid, sparse readout, rare resets.
    do_reset();
    rtrig = 1'b0;
    phase_left = 5;
    for (int c = 0; c < 15000; c++) begin
      bit [1:0] rd;
      if (phase_left == 0) begin
        rtrig = !rtrig;
        phase_left = rtrig ? $urandom_range(1, 450) : $urandom_range(1, 60);
      end
      phase_left--;
      rd[0]  = ($urandom_range(0, 119) == 0);
      rd[1]  = ($urandom_range(0, 119) == 0);
      tb_clr = ($urandom_range(0, 63) == 0);
      reset  = ($urandom_range(0, 4999) == 0);
      step(rtrig, $urandom_range(0, 3) != 0, rd);
    end
    reset  = 1'b0;
    tb_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
